// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_LAT   = MDU_WIDTH + 2;

    function automatic logic is_iter(input logic [2:0] op);
        return !op[2];
    endfunction
endpackage

// File: rtl/mult_div_core.sv
// mult_div_core: one shift-add multiply or restoring shift-subtract divide step.
module mult_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, m & {WIDTH{q[0]}}};
        shifted  = {acc, q[WIDTH-1]};
        ge       = shifted >= {1'b0, m};
        diff     = shifted[WIDTH-1:0] - m;
        acc_next = div ? (ge ? diff : shifted[WIDTH-1:0]) : sum[WIDTH:1];
        q_next   = div ? {q[WIDTH-2:0], ge} : {sum[0], q[WIDTH-1:1]};
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO registers with a fixed-latency iterative MULT/MULTU/DIV/DIVU engine.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    state_t             state, state_n;
    logic [WIDTH-1:0]   acc, qr, m, acc_n, qr_n;
    logic [CW-1:0]      count;
    logic               is_div, neg_q, neg_r, dz;
    logic               idle_start, sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs, hi_fix, lo_fix;
    logic [2*WIDTH-1:0] prod;

    mult_div_core #(.WIDTH(WIDTH)) u_core (
        .div      (is_div),
        .acc      (acc),
        .q        (qr),
        .m        (m),
        .acc_next (acc_n),
        .q_next   (qr_n)
    );

    always_comb begin
        idle_start = state == S_IDLE && start;
        sgn        = op == OP_MULT || op == OP_DIV;
        a_neg      = sgn & a[WIDTH-1];
        b_neg      = sgn & b[WIDTH-1];
        a_abs      = a_neg ? -a : a;
        b_abs      = b_neg ? -b : b;
    end

    // Sign correction: neg_q is the product sign for multiplies, quotient sign for divides.
    always_comb begin
        prod   = neg_q ? -{acc, qr} : {acc, qr};
        lo_fix = is_div ? (dz ? '1 : neg_q ? -qr : qr) : prod[WIDTH-1:0];
        hi_fix = is_div ? (neg_r ? -acc : acc) : prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state == S_IDLE ? (start && is_iter(op) ? S_RUN : S_IDLE) :
                  state == S_RUN  ? (count == CW'(WIDTH - 1) ? S_FIX : S_RUN) : S_IDLE;
    end

    always_comb begin
        busy = state != S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            qr     <= '0;
            m      <= '0;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= state == S_FIX;
            if (idle_start && is_iter(op)) begin
                is_div <= op[1];
                m      <= b_abs;
                acc    <= '0;
                qr     <= a_abs;
                count  <= '0;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dz     <= b == '0;
            end else if (state == S_RUN) begin
                acc   <= acc_n;
                qr    <= qr_n;
                count <= count + 1'b1;
            end else if (state == S_FIX) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
            if (idle_start && op == OP_MTHI) hi <= a;
            if (idle_start && op == OP_MTLO) lo <= a;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          checks = 0;
    int          errors = 0;
    int          cyc, nb, nd;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .start (start),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int c, output int n);
        c = 0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            c++;
            if (done) break;
            n += int'(busy);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        pulse(o, x, y);
        chk({tag, "_busy_start"}, busy, 1'b1);
        a = ~x;
        b = ~y;
        wait_done(cyc, nb);
        chk({tag, "_latency"}, cyc, MDU_LAT - 1);
        chk({tag, "_busy_cycles"}, nb + 1, MDU_LAT - 1);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        #12;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(posedge clk);
        #1 chk("done_one_cycle", done, 1'b0);

        run("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run("div_neg_dividend", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_neg_divisor", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run("divu_small", OP_DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
        run("div_overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run("div_by_zero_s", OP_DIV, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF);
        run("divu_by_zero", OP_DIVU, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF);

        pulse(OP_MTHI, 32'h00000055, 32'h0);
        chk("mthi_hi", hi, 32'h00000055);
        chk("mthi_lo", lo, 32'hFFFFFFFF);
        chk("mthi_busy", busy, 1'b0);
        chk("mthi_done", done, 1'b0);

        pulse(3'b110, 32'h00000099, 32'h1);
        chk("reserved_hi", hi, 32'h00000055);
        chk("reserved_lo", lo, 32'hFFFFFFFF);
        chk("reserved_busy", busy, 1'b0);

        pulse(OP_MTLO, 32'h0, 32'h0);
        pulse(OP_MTHI, 32'h0, 32'h0);
        pulse(OP_MULTU, 32'h00000003, 32'h00000005);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        pulse(OP_MTLO, 32'h000000AA, 32'h0);
        chk("mtlo_busy_lo", lo, 32'h0);
        wait_done(cyc, nb);
        chk("mtlo_busy_latency", cyc, MDU_LAT - 6);
        chk("mtlo_busy_hi", hi, 32'h0);
        chk("mtlo_busy_lo_final", lo, 32'h0000000F);

        pulse(OP_DIVU, 32'h00000100, 32'h00000007);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_done", done, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 nd += int'(done);
        end
        chk("abort_no_done", nd, 0);

        run("multu_after_rst", OP_MULTU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multicycle MIPS datapath; sits directly downstream of the A/B operand buffer and consumes its two registered outputs as rs (a) and rt (b).
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds architectural HI/LO registers, which feed the MFHI/MFLO write-back mux.
- Controller drives a start/op handshake, stalls on busy and proceeds on done.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits; the product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand rs; also the MTHI/MTLO source.
- b  input  WIDTH  operand rt.
- start  input  1  one-cycle request; sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no effect).
- busy  output  1  high while an iterative op is in flight.
- done  output  1  one-cycle pulse when new HI/LO from MULT/DIV become valid.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, while rst=1): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration count=0, internal operand/accumulator registers=0.
- Reset mid-operation aborts immediately: no done pulse, and HI/LO read 0.
- FSM states:
  - IDLE: on start with op in {MULT..DIVU} at edge k: latch |a| and |b| (raw values for unsigned ops), latch the result-sign flags, count=0, go to RUN, busy=1 after edge k.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, on edges k+1..k+32. When count reaches WIDTH-1, go to FIX.
  - FIX (edge k+33): apply two's-complement sign correction, write hi/lo, go to IDLE. After edge k+33, busy=0 and done=1 for exactly one cycle.
- Latency: start-to-done is WIDTH+2 = 34 clocks, constant for all four iterative ops, including divide-by-zero.
- Multiply result: hi:lo = full 64-bit product.
  - MULT: signed x signed.
  - MULTU: unsigned x unsigned.
- Divide result: lo = quotient, hi = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU is unsigned.
- Divide by zero (b=0, DIV or DIVU): lo=all ones, hi=a unmodified; same latency and done pulse.
- DIV overflow (a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0 (natural wrap, no trap).
- MTHI/MTLO in IDLE:
  - hi (or lo) <= a at that edge.
  - busy stays 0 and no done pulse.
  - The other register is unchanged.
- Reserved op with start: no state change.
- start while busy=1, any op including MTHI/MTLO: ignored, with no effect on the in-flight result.
- start in the same cycle as done: accepted, since the FSM is already IDLE.
- hi/lo hold their prior values throughout RUN; they update only at FIX or on MTHI/MTLO. No partial results are visible.
- Operands are sampled only at the accepting edge; a/b may change freely during RUN.

Decomposition:
- Shared package mdu_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - FSM state encodings: S_IDLE, S_RUN, S_FIX.
  - MDU_LAT = WIDTH+2.
- Natural sub-module: mult_div_core, the per-iteration combinational step (add/shift or subtract/restore on the accumulator pair).
- mult_div_unit keeps the FSM, counter, sign handling and HI/LO registers.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF -> done on the 34th clock after the start edge; hi=FFFFFFFE, lo=00000001; busy high for exactly 33 cycles.
- MULT a=FFFFFFFE b=00000003 -> hi=FFFFFFFF, lo=FFFFFFFA. Then DIV a=FFFFFFF9 b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=00000007 b=00000002 -> lo=00000003, hi=00000001. Then DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000.
- DIVU a=00001234 b=00000000 -> after 34 clocks, lo=FFFFFFFF, hi=00001234, done pulse.
- MTHI a=00000055 in IDLE -> hi=00000055 next cycle, busy=0, done=0, lo unchanged. MTLO a=000000AA pulsed while a MULTU 3x5 is busy -> ignored; final hi=0, lo=0000000F.
- rst=1 asynchronously at cycle 10 of a DIVU -> busy=0, hi=lo=0 immediately, no done. After release, MULTU 2x3 -> lo=00000006, hi=0 after 34 clocks.
